instr_encoder_loader: RTL

//  Encodes field-level instructions (op/src/dst/imm) into 16-bit instruction words
//  and streams them into instruction memory from a base address. It is the write side
//  of the instruction-decode path and produces exactly the format the ID stage decodes.

---
 rtl/instr_encoder_loader_pkg.sv | 66 ++++++
 rtl/instr_encoder_loader_sync_fifo.sv | 67 ++++++
 rtl/instr_encoder_loader.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/instr_encoder_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module : instr_encoder_loader_pkg
// Brief  : Opcodes, instruction field positions, loader FSM encoding and the
//          field-to-word encoder. The ID stage imports the same package, so
//          the encoder and the decoder always agree on the word layout.
// Rev    : 1.0 - initial release
// ============================================================================
package instr_encoder_loader_pkg;

    localparam int WORD_W = 16;

    // Opcodes
    localparam logic [3:0] OP_MOV = 4'd0;
    localparam logic [3:0] OP_LW  = 4'd1;
    localparam logic [3:0] OP_J   = 4'd2;
    localparam logic [3:0] OP_BEQ = 4'd3;
    localparam logic [3:0] OP_BLT = 4'd4;

    // Field bit positions inside the 16-bit instruction word
    localparam int OP_LSB  = 0;
    localparam int OP_MSB  = 3;
    localparam int SRC_LSB = 4;
    localparam int SRC_MSB = 8;
    localparam int DST_LSB = 9;
    localparam int DST_MSB = 13;
    localparam int IMM_LSB = 4;
    localparam int IMM_MSB = 15;

    // Loader session state
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_DRAIN = 2'b10
    } load_state_t;

    // Register-form ops carry src/dst, control-flow ops carry imm; anything
    // else keeps only its opcode so the decoder can still see what arrived.
    function automatic logic [WORD_W-1:0] encode_instr(
        input logic [3:0]  op,
        input logic [4:0]  src,
        input logic [4:0]  dst,
        input logic [11:0] imm
    );
        logic [WORD_W-1:0] w_word;
        w_word                 = '0;
        w_word[OP_MSB:OP_LSB]  = op;
        case (op)
            OP_MOV, OP_LW: begin
                w_word[SRC_MSB:SRC_LSB] = src;
                w_word[DST_MSB:DST_LSB] = dst;
            end
            OP_J, OP_BEQ, OP_BLT: begin
                w_word[IMM_MSB:IMM_LSB] = imm;
            end
            default: ;
        endcase
        return w_word;
    endfunction

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op <= OP_BLT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_encoder_loader_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module : instr_encoder_loader_sync_fifo
// Brief  : Single-clock FIFO holding encoded words plus their last flag.
//          DEPTH must be a power of two so the pointers wrap naturally.
//          A push while full is honoured when a pop happens in the same cycle.
// Rev    : 1.0 - initial release
// ============================================================================
module instr_encoder_loader_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 17
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_full
);
    localparam int             PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] C_DEPTH = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == C_DEPTH);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rdata   = r_mem[r_rd_ptr];

    // Storage array; contents are only meaningful where r_count says so
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers and occupancy; reset flushes the FIFO
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module : instr_encoder_loader
// Brief  : Encodes op/src/dst/imm fields into 16-bit instruction words and
//          streams them into instruction RAM from a captured base address.
//          Optional macro ILLEGAL_OP_TRAP_EN: opcodes above BLT are accepted
//          but dropped, and raise a sticky o_err until reset.
// Rev    : 1.0 - initial release
// ============================================================================
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int AW    = 8,
    parameter int DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [AW-1:0]     i_base,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [3:0]        i_op,
    input  logic [4:0]        i_src,
    input  logic [4:0]        i_dst,
    input  logic [11:0]       i_imm,
    input  logic              i_last,
    input  logic              i_mem_ready,
    output logic              o_we,
    output logic [AW-1:0]     o_waddr,
    output logic [WORD_W-1:0] o_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);
    localparam int ENTRY_W = WORD_W + 1;

    load_state_t         r_state;
    load_state_t         w_next_state;
    logic [AW-1:0]       r_addr;
    logic                r_fin;
    logic                r_done;
    logic                w_accept;
    logic                w_drop;
    logic                w_push;
    logic                w_retire;
    logic                w_fifo_empty;
    logic                w_fifo_full;
    logic                w_head_last;
    logic [WORD_W-1:0]   w_enc_word;
    logic [WORD_W-1:0]   w_head_word;
    logic [ENTRY_W-1:0]  w_head_entry;

    assign w_enc_word = encode_instr(i_op, i_src, i_dst, i_imm);
    assign o_ready    = (r_state == ST_LOAD) && !w_fifo_full;
    assign w_accept   = i_valid && o_ready;

`ifdef ILLEGAL_OP_TRAP_EN
    logic r_err;
    assign w_drop = !is_legal_op(i_op);
    assign o_err  = r_err;

    // Sticky illegal-opcode flag, cleared only by reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept && w_drop) begin
            r_err <= 1'b1;
        end
    end
`else
    assign w_drop = 1'b0;
    assign o_err  = 1'b0;
`endif

    assign w_push   = w_accept && !w_drop;
    assign o_we     = !w_fifo_empty && (r_state != ST_IDLE);
    assign w_retire = o_we && i_mem_ready;

    assign {w_head_last, w_head_word} = w_head_entry;
    // Word is zero when nothing is offered; otherwise the FIFO head, which
    // stays put until the memory takes it.
    assign o_wdata = o_we ? w_head_word : '0;
    assign o_waddr = r_addr;
    assign o_busy  = (r_state != ST_IDLE);
    assign o_done  = r_done;

    instr_encoder_loader_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_wdata ({i_last, w_enc_word}),
        .i_pop   (w_retire),
        .o_rdata (w_head_entry),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    // Session state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Session sequencing: start opens, accepted last closes input, drain ends
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (i_start)                    w_next_state = ST_LOAD;
            ST_LOAD:  if (w_accept && i_last)         w_next_state = ST_DRAIN;
            ST_DRAIN: if (w_fifo_empty && r_fin)      w_next_state = ST_IDLE;
            default:                                  w_next_state = ST_IDLE;
        endcase
    end

    // Write address, end-of-session tracking and the done pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr <= '0;
            r_fin  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == ST_DRAIN) && (w_next_state == ST_IDLE);
            if ((r_state == ST_IDLE) && i_start) begin
                r_addr <= i_base;
                r_fin  <= 1'b0;
            end else begin
                if (w_retire) begin
                    r_addr <= r_addr + 1'b1;
                end
                // A dropped last word still closes the session
                if ((w_retire && w_head_last) || (w_accept && i_last && w_drop)) begin
                    r_fin <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
